// File: rtl/spine_port_scheduler_pkg.sv
// Shared widths, output state encoding and the
// destination-to-port route function for the spine scheduler.
package spine_port_scheduler_pkg;

  localparam int NUM_PORTS_DEF = 11;
  localparam int DEST_W        = 6;
  localparam int PORT_W        = 4;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Own group fans out to leaf ports 1..4; other groups
  // 1..8 pack into ports 5.. skipping our own group.
  function automatic logic [PORT_W-1:0] route(
    input logic [DEST_W-1:0] dest,
    input logic [3:0]        gid,
    input int                nports
  );
    logic [3:0] g;
    int         p;
    g = dest[5:2];
    p = 0;
    if (g == gid)
      p = int'(dest[1:0]) + 1;
    else if (g >= 4'd1 && g <= 4'd8)
      p = (g < gid) ? int'(g) + 4 : int'(g) + 3;
    if (p > nports)
      p = 0;
    return PORT_W'(p);
  endfunction

endpackage

// File: rtl/spine_port_scheduler_if.sv
// Flit request / grant bundle between the spine
// input ports and the scheduler.
interface spine_port_scheduler_if
  import spine_port_scheduler_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF
) ();

  logic [NUM_PORTS-1:0]        in_valid;
  logic [DEST_W*NUM_PORTS-1:0] in_dest;
  logic [NUM_PORTS-1:0]        in_last;
  logic [NUM_PORTS-1:0]        out_ready;
  logic [NUM_PORTS-1:0]        in_grant;
  logic [PORT_W*NUM_PORTS-1:0] in_sel;
  logic [PORT_W*NUM_PORTS-1:0] out_src;
  logic [NUM_PORTS-1:0]        drop;

  modport master (
    output in_valid, in_dest, in_last, out_ready,
    input  in_grant, in_sel, out_src, drop
  );

  modport slave (
    input  in_valid, in_dest, in_last, out_ready,
    output in_grant, in_sel, out_src, drop
  );

endinterface

// File: rtl/spine_rr_arbiter.sv
// Round-robin pick: first request at or after ptr,
// wrapping at N, returned one-hot.
module spine_rr_arbiter
  import spine_port_scheduler_pkg::*;
#(
  parameter int N = NUM_PORTS_DEF
) (
  input  logic [N-1:0]      req,
  input  logic [PORT_W-1:0] ptr,
  output logic [N-1:0]      gnt
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N)
        idx = idx - N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spine_port_scheduler.sv
// Wormhole output scheduler: per-output lock/owner with
// round-robin arbitration, inputs bound until tail.
module spine_port_scheduler
  import spine_port_scheduler_pkg::*;
#(
  parameter logic [3:0] GROUP_ID  = 4'b0101,
  parameter int         NUM_PORTS = NUM_PORTS_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  spine_port_scheduler_if.slave bus
);

  typedef logic [PORT_W-1:0] idx_t;

  logic [0:0]           st    [NUM_PORTS];
  idx_t                 owner [NUM_PORTS];
  idx_t                 ptr   [NUM_PORTS];
  idx_t                 rt    [NUM_PORTS];
  idx_t                 bidx  [NUM_PORTS];
  idx_t                 widx  [NUM_PORTS];
  logic [NUM_PORTS-1:0] req   [NUM_PORTS];
  logic [NUM_PORTS-1:0] gnt   [NUM_PORTS];
  logic [NUM_PORTS-1:0] bound;
  logic [NUM_PORTS-1:0] grant;
  logic [NUM_PORTS-1:0] rel;

  // Input binding is derived from the output owners,
  // so an input can never be bound twice.
  always_comb begin
    bound = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      rt[k]   = route(bus.in_dest[DEST_W*k +: DEST_W],
                      GROUP_ID, NUM_PORTS);
      bidx[k] = '0;
    end
    for (int j = 0; j < NUM_PORTS; j++)
      for (int k = 0; k < NUM_PORTS; k++)
        if (st[j] == ST_LOCKED && owner[j] == idx_t'(k)) begin
          bound[k] = 1'b1;
          bidx[k]  = idx_t'(j);
        end
  end

  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      req[j] = '0;
      for (int k = 0; k < NUM_PORTS; k++)
        req[j][k] = bus.in_valid[k] && !bound[k] &&
                    rt[k] == idx_t'(j + 1);
    end
  end

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_arb
    spine_rr_arbiter #(.N(NUM_PORTS)) u_arb (
      .req (req[j]),
      .ptr (ptr[j]),
      .gnt (gnt[j])
    );
  end

  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++)
      grant[k] = rst_n && bus.in_valid[k] && bound[k] &&
                 bus.out_ready[bidx[k]];
  end

  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      widx[j] = '0;
      for (int k = 0; k < NUM_PORTS; k++)
        if (gnt[j][k])
          widx[j] = idx_t'(k);
      rel[j] = st[j] == ST_LOCKED && grant[owner[j]] &&
               bus.in_last[owner[j]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        st[j]    <= ST_IDLE;
        owner[j] <= '0;
        ptr[j]   <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (st[j] == ST_IDLE && |gnt[j]) begin
          st[j]    <= ST_LOCKED;
          owner[j] <= widx[j];
          ptr[j]   <= (widx[j] == idx_t'(NUM_PORTS - 1)) ?
                      '0 : widx[j] + 1'b1;
        end else if (rel[j]) begin
          st[j] <= ST_IDLE;
        end
      end
    end
  end

  always_comb begin
    bus.in_grant = '0;
    bus.drop     = '0;
    bus.in_sel   = '0;
    bus.out_src  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      bus.in_grant[k] = grant[k];
      bus.drop[k]     = rst_n && bus.in_valid[k] &&
                        !bound[k] && rt[k] == '0;
      if (rst_n && bound[k])
        bus.in_sel[PORT_W*k +: PORT_W] = bidx[k] + idx_t'(1);
    end
    for (int j = 0; j < NUM_PORTS; j++)
      if (rst_n && st[j] == ST_LOCKED)
        bus.out_src[PORT_W*j +: PORT_W] = owner[j] + idx_t'(1);
  end

endmodule

// File: tb/tb_spine_port_scheduler.sv
// Directed cycle-by-cycle vectors for the spine
// port scheduler, compared just before each rising edge.
module tb_spine_port_scheduler;

  localparam int N = 11;

  typedef struct {
    logic        rn;
    logic [10:0] v;
    logic [10:0] l;
    logic [10:0] r;
    logic [65:0] d;
    logic [10:0] eg;
    logic [10:0] ed;
    logic [43:0] es;
    logic [43:0] eo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  vec_t tbl [$];

  spine_port_scheduler_if #(.NUM_PORTS(N)) bus ();

  spine_port_scheduler #(
    .GROUP_ID  (4'b0101),
    .NUM_PORTS (N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] b(input int k);
    return 11'(1) << k;
  endfunction

  function automatic logic [65:0] d1(input int k,
                                     input logic [5:0] x);
    logic [65:0] t;
    t = '0;
    t[6*k +: 6] = x;
    return t;
  endfunction

  function automatic logic [43:0] s1(input int k,
                                     input logic [3:0] x);
    logic [43:0] t;
    t = '0;
    t[4*k +: 4] = x;
    return t;
  endfunction

  function automatic vec_t mk(
    input logic rn, input logic [10:0] v,
    input logic [10:0] l, input logic [10:0] r,
    input logic [65:0] d, input logic [10:0] eg,
    input logic [10:0] ed, input logic [43:0] es,
    input logic [43:0] eo);
    vec_t t;
    t.rn = rn; t.v = v; t.l = l; t.r = r; t.d = d;
    t.eg = eg; t.ed = ed; t.es = es; t.eo = eo;
    return t;
  endfunction

  task automatic apply(input vec_t t, input string name);
    @(negedge clk);
    rst_n         = t.rn;
    bus.in_valid  = t.v;
    bus.in_last   = t.l;
    bus.out_ready = t.r;
    bus.in_dest   = t.d;
    #2;
    nvec++;
    if (bus.in_grant !== t.eg || bus.in_sel !== t.es ||
        bus.out_src !== t.eo || bus.drop !== t.ed) begin
      nerr++;
      $display("FAIL %s: grant=%h sel=%h src=%h drop=%h, expected grant=%h sel=%h src=%h drop=%h",
               name, bus.in_grant, bus.in_sel, bus.out_src,
               bus.drop, t.eg, t.es, t.eo, t.ed);
    end
  endtask

  localparam logic [10:0] A = 11'h7ff;
  localparam logic [10:0] Z = 11'h000;

  initial begin
    logic [65:0] da, db, dc, dr;
    logic [10:0] m01, ra;
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.out_ready = '0;
    bus.in_dest   = '0;
    da  = d1(5, 6'b010110);
    db  = d1(0, 6'b000100) | d1(1, 6'b000100);
    m01 = b(0) | b(1);

    tbl.push_back(mk(0, A, Z, A, {11{6'b000100}}, Z, Z, 0, 0));
    tbl.push_back(mk(0, A, Z, A, {11{6'b000100}}, Z, Z, 0, 0));
    tbl.push_back(mk(1, Z, Z, A, 0, Z, Z, 0, 0));
    tbl.push_back(mk(1, b(5), b(5), A, da, Z, Z, 0, 0));
    tbl.push_back(mk(1, b(5), b(5), A, da, b(5), Z,
                     s1(5, 3), s1(2, 6)));
    tbl.push_back(mk(1, Z, Z, A, 0, Z, Z, 0, 0));
    tbl.push_back(mk(1, m01, Z, A, db, Z, Z, 0, 0));
    tbl.push_back(mk(1, m01, Z, A, db, b(0), Z,
                     s1(0, 5), s1(4, 1)));
    tbl.push_back(mk(1, m01, Z, A, db, b(0), Z,
                     s1(0, 5), s1(4, 1)));
    tbl.push_back(mk(1, m01, b(0), A, db, b(0), Z,
                     s1(0, 5), s1(4, 1)));
    tbl.push_back(mk(1, b(1), Z, A, db, Z, Z, 0, 0));
    tbl.push_back(mk(1, b(1), Z, A, db, b(1), Z,
                     s1(1, 5), s1(4, 2)));
    tbl.push_back(mk(1, b(1), Z, A, db, b(1), Z,
                     s1(1, 5), s1(4, 2)));
    tbl.push_back(mk(1, b(1), b(1), A, db, b(1), Z,
                     s1(1, 5), s1(4, 2)));
    tbl.push_back(mk(1, m01, Z, A, db, Z, Z, 0, 0));
    tbl.push_back(mk(1, m01, b(0), A, db, b(0), Z,
                     s1(0, 5), s1(4, 1)));
    tbl.push_back(mk(1, b(1), b(1), A, db, Z, Z, 0, 0));
    tbl.push_back(mk(1, b(1), b(1), A, db, b(1), Z,
                     s1(1, 5), s1(4, 2)));
    tbl.push_back(mk(1, Z, Z, A, 0, Z, Z, 0, 0));
    tbl.push_back(mk(1, b(2), Z, A, d1(2, 6'b000001),
                     Z, b(2), 0, 0));
    tbl.push_back(mk(1, Z, Z, A, 0, Z, Z, 0, 0));

    foreach (tbl[i])
      apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Stall with in_dest rewritten mid-packet.
    dc = d1(7, 6'b001100);
    dr = d1(7, 6'b010100);
    ra = A & ~b(6);
    apply(mk(1, b(7), Z, A, dc, Z, Z, 0, 0), "stall_req");
    apply(mk(1, b(7), Z, A, dc, b(7), Z,
             s1(7, 7), s1(6, 8)), "stall_beat1");
    for (int i = 0; i < 4; i++)
      apply(mk(1, b(7), Z, ra, dr, Z, Z,
               s1(7, 7), s1(6, 8)),
            $sformatf("stall_hold%0d", i));
    apply(mk(1, b(7), b(7), A, dr, b(7), Z,
             s1(7, 7), s1(6, 8)), "stall_resume");
    apply(mk(1, Z, Z, A, 0, Z, Z, 0, 0), "stall_done");

    // Mid-packet reset; afterwards ptr 0 favours input 2 over 5.
    dc = d1(3, 6'b000100);
    db = d1(2, 6'b000100) | d1(5, 6'b000100);
    apply(mk(1, b(3), Z, A, dc, Z, Z, 0, 0), "rst_req");
    apply(mk(1, b(3), Z, A, dc, b(3), Z,
             s1(3, 5), s1(4, 4)), "rst_beat1");
    apply(mk(0, b(3), Z, A, dc, Z, Z, 0, 0), "rst_low");
    apply(mk(1, b(2) | b(5), Z, A, db, Z, Z, 0, 0),
          "rst_rearb");
    apply(mk(1, b(2) | b(5), b(2), A, db, b(2), Z,
             s1(2, 5), s1(4, 3)), "rst_ptr0");
    apply(mk(1, Z, Z, A, 0, Z, Z, 0, 0), "rst_done");

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/spine_port_scheduler.md
SPINE_PORT_SCHEDULER -- requirements
Module: spine_port_scheduler

Interface
REQ-001 SHALL have parameter GROUP_ID, default 4'b0101, meaning the local group number.
REQ-002 SHALL have parameter NUM_PORTS, default 11, meaning spine port count; index k maps to port number k+1.
REQ-003 SHALL have clk, input, 1, the single clock.
REQ-004 SHALL have rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have in_valid, input, NUM_PORTS: input port k holds a flit.
REQ-006 SHALL have in_dest, input, 6*NUM_PORTS, {GroupID[3:0],LeafID[1:0]} per input.
REQ-007 SHALL have in_last, input, NUM_PORTS: the flit is the packet tail.
REQ-008 SHALL have out_ready, input, NUM_PORTS: output port j accepts a flit.
REQ-009 SHALL have in_grant, output, NUM_PORTS: input k's flit transfers this cycle.
REQ-010 SHALL have in_sel, output, 4*NUM_PORTS: output port number bound to input k, 0 if unbound.
REQ-011 SHALL have out_src, output, 4*NUM_PORTS: input port number owning output j, 0 if idle.
REQ-012 SHALL have drop, output, NUM_PORTS: input k's flit is unroutable and discarded this cycle.

Function
REQ-013 Route SHALL be combinational per input: dest group == GROUP_ID -> leaf 0..3 gives port 1..4; groups 1..8 other than GROUP_ID map in ascending order to ports 5..11; any other group gives 0.
REQ-014 Each output SHALL have two states, IDLE and LOCKED, with owner index and round-robin pointer.
REQ-015 Each input SHALL be FREE or BOUND; a BOUND input SHALL NOT request any other output.
REQ-016 IDLE output j SHALL pick, among FREE valid inputs routed to j, the first at or after ptr[j] (wrapping at NUM_PORTS), and at the clock edge go LOCKED with that owner, binding the input.
REQ-017 On lock, ptr[j] SHALL become owner+1, wrapping to 0 past NUM_PORTS-1.
REQ-018 in_grant[k] SHALL equal in_valid[k] AND bound AND out_ready[bound output], combinationally.
REQ-019 A granted flit with in_last SHALL return the output to IDLE and the input to FREE at that edge.
REQ-020 Arbitration latency SHALL be one cycle: first beat granted earliest the cycle after the request; back-to-back packets on one output are separated by exactly one idle cycle.
REQ-021 in_dest of a BOUND input SHALL be ignored until its tail transfers.
REQ-022 A FREE valid input with route 0 SHALL assert drop for that cycle and never bind.
REQ-023 Route equal to the input's own port number SHALL be handled as any other route.
REQ-024 Distinct outputs SHALL lock independently in the same cycle.
REQ-025 out_ready low SHALL stall grants without releasing the lock.

Reset
REQ-026 rst_n low at an edge SHALL clear all locks and bindings and zero all pointers; in_grant, in_sel, out_src and drop SHALL read 0 while rst_n is low, including mid-packet.
REQ-027 The first arbitration SHALL occur at the first edge with rst_n high.

Structure
REQ-028 A shared package SHALL hold NUM_PORTS default, address/port widths, the IDLE/LOCKED encoding and the route function.
REQ-029 One sub-module, spine_rr_arbiter (request vector, pointer -> one-hot winner), SHALL be instantiated once per output.

Verification
REQ-030 rst_n=0 for 2 cycles with all in_valid=1 -> all outputs 0, no lock.
REQ-031 Input 5, dest 6'b010110, single-beat, out_ready all 1 -> next cycle in_sel[5]=3, out_src[2]=6, in_grant[5]=1; then both return to 0.
REQ-032 Inputs 0 and 1 both dest 6'b000100, 3-beat packets, same cycle -> input 0 owns output 4 for 3 grants, 1 idle cycle, then input 1 for 3 grants; repeat -> input 0 wins next (pointer 2 wraps back).
REQ-033 Input 2, dest 6'b000001 -> drop[2]=1 that cycle, out_src all 0.
REQ-034 Input 7 bound to output 6, out_ready[6]=0 for 4 cycles mid-packet, in_dest changed to 6'b010100 -> in_grant[7]=0, lock and in_sel[7]=7 held, resumes on out_ready=1.
REQ-035 rst_n=0 for 1 cycle mid-packet -> all locks clear; new request after reset arbitrates from pointer 0.
